// File: rtl/tinyqv_instr_prefetch_if.sv
// ---------------------------------------------------------------------------
// tinyqv_instr_prefetch_if
//
// Bundles the CPU-side and memory-controller-side signals of the TinyQV
// instruction prefetch buffer.
//
//   CPU side      : cpu_jump, cpu_jump_addr, cpu_take            (to prefetch)
//                   instr_valid, instr_data, instr_compressed,
//                   instr_pc                                     (from prefetch)
//   Memory side   : instr_ready, instr_word                      (to prefetch)
//                   instr_addr, instr_jump, instr_fetch_stall    (from prefetch)
//
// Modports: slave = the prefetch buffer, master = its environment.
// Addresses are halfword addresses (byte address bits [23:1]).
// ---------------------------------------------------------------------------
interface tinyqv_instr_prefetch_if;
    logic        cpu_jump;
    logic [22:0] cpu_jump_addr;
    logic        cpu_take;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_compressed;
    logic [22:0] instr_pc;
    logic [22:0] instr_addr;
    logic        instr_jump;
    logic        instr_fetch_stall;
    logic        instr_ready;
    logic [31:0] instr_word;

    modport slave (
        input  cpu_jump, cpu_jump_addr, cpu_take, instr_ready, instr_word,
        output instr_valid, instr_data, instr_compressed, instr_pc,
               instr_addr, instr_jump, instr_fetch_stall
    );

    modport master (
        output cpu_jump, cpu_jump_addr, cpu_take, instr_ready, instr_word,
        input  instr_valid, instr_data, instr_compressed, instr_pc,
               instr_addr, instr_jump, instr_fetch_stall
    );
endinterface

// File: rtl/tinyqv_instr_prefetch.sv
// ---------------------------------------------------------------------------
// tinyqv_instr_prefetch
//
// Instruction prefetch buffer between the TinyQV memory controller's
// instruction port and the decoder. Generates the sequential fetch address,
// stores each returned 32-bit word as two halfwords in a small FIFO and
// presents one aligned 16- or 32-bit instruction at a time.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - tinyqv_instr_prefetch_if.slave (CPU and memory-controller signals)
//
// Parameters:
//   DEPTH_HW   - FIFO depth in halfwords (power of 2, >= 4)
//   RESET_ADDR - halfword address of the first fetch after reset
// ---------------------------------------------------------------------------
module tinyqv_instr_prefetch #(
    parameter int unsigned DEPTH_HW   = 8,
    parameter logic [22:0] RESET_ADDR = 23'h000000
) (
    input  logic                          clk,
    input  logic                          rst,
    tinyqv_instr_prefetch_if.slave        bus
);

    localparam int unsigned PW = $clog2(DEPTH_HW);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [15:0] hw_buf [DEPTH_HW];
    ptr_t        rd;
    ptr_t        wr;
    cnt_t        count;
    logic [22:0] pc;
    logic [22:0] addr;
    logic        discard;

    logic [15:0] lo;
    logic [15:0] hi;
    logic        compressed;
    logic        valid;
    logic        room;
    logic        push;
    logic        pop;
    cnt_t        pop_n;
    cnt_t        count_next;

    // NOTE: every always_comb output is given a value on every path (here,
    // unconditionally) so no latch is inferred.
    always_comb begin
        lo         = hw_buf[rd];
        hi         = hw_buf[rd + ptr_t'(1)];
        compressed = (lo[1:0] != 2'b11);
        valid      = ((count >= cnt_t'(1)) && compressed) || (count >= cnt_t'(2));
        // At least two free halfwords are needed to accept a full word.
        room       = (count <= cnt_t'(DEPTH_HW - 2));
        push       = bus.instr_ready && !bus.cpu_jump && !discard && room;
        pop        = bus.cpu_take && valid && !bus.cpu_jump;
        pop_n      = compressed ? cnt_t'(1) : cnt_t'(2);
        count_next = count + (push ? cnt_t'(2) : cnt_t'(0)) - (pop ? pop_n : cnt_t'(0));
    end

    assign bus.instr_valid       = valid;
    assign bus.instr_data        = {hi, lo};
    assign bus.instr_compressed  = compressed;
    assign bus.instr_pc          = pc;
    assign bus.instr_addr        = addr;
    assign bus.instr_jump        = bus.cpu_jump;
    // Driven from the registered count only; a same-cycle pop does not release it.
    assign bus.instr_fetch_stall = !room;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd      <= '0;
            wr      <= '0;
            count   <= '0;
            pc      <= RESET_ADDR;
            addr    <= RESET_ADDR;
            discard <= 1'b0;
        end else if (bus.cpu_jump) begin
            // Jump wins over push and pop; the word already in flight through
            // the controller's registered restart is dropped via discard.
            rd      <= '0;
            wr      <= '0;
            count   <= '0;
            pc      <= bus.cpu_jump_addr;
            addr    <= bus.cpu_jump_addr;
            discard <= 1'b1;
        end else begin
            discard <= 1'b0;
            count   <= count_next;
            if (push) begin
                wr   <= wr + ptr_t'(2);
                addr <= addr + 23'd2;
            end
            if (pop) begin
                rd <= rd + ptr_t'(pop_n);
                pc <= pc + 23'(pop_n);
            end
        end
    end

    // NOTE: the halfword array is not reset; count gates every read, so its
    // contents are never observed before being written.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            hw_buf[wr]              <= bus.instr_word[15:0];
            hw_buf[wr + ptr_t'(1)]  <= bus.instr_word[31:16];
        end
    end

    // A word returned while fewer than two halfwords are free breaks the
    // stall protocol; it is dropped above, and flagged here in simulation.
    always_ff @(posedge clk) begin
        if (!rst && bus.instr_ready && !bus.cpu_jump && !discard) begin
            overflow_chk: assert (room)
                else $error("tinyqv_instr_prefetch: push into full buffer dropped");
        end
    end

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// ---------------------------------------------------------------------------
// tb_tinyqv_instr_prefetch
//
// Directed bench for tinyqv_instr_prefetch (DEPTH_HW=8, RESET_ADDR=0x100).
// Inputs change 1 ns after the rising edge, outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_tinyqv_instr_prefetch;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    tinyqv_instr_prefetch_if bus ();

    tinyqv_instr_prefetch #(
        .DEPTH_HW   (8),
        .RESET_ADDR (23'h000100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
            else begin
                mismatched++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word returned by the controller, then inputs idle and settled.
    task automatic push(input logic [31:0] w);
        bus.instr_ready = 1'b1;
        bus.instr_word  = w;
        tick();
        bus.instr_ready = 1'b0;
        #1;
    endtask

    task automatic take_one();
        bus.cpu_take = 1'b1;
        tick();
        bus.cpu_take = 1'b0;
        #1;
    endtask

    // Jump cycle followed by the discard cycle, no words returned.
    task automatic do_jump(input logic [22:0] a);
        bus.cpu_jump      = 1'b1;
        bus.cpu_jump_addr = a;
        tick();
        bus.cpu_jump = 1'b0;
        tick();
        #1;
    endtask

    initial begin
        compared          = 0;
        mismatched        = 0;
        rst               = 1'b1;
        bus.cpu_jump      = 1'b0;
        bus.cpu_jump_addr = '0;
        bus.cpu_take      = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.instr_word    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_jump",  32'(bus.instr_jump), 32'd0);
        check("rst_stall", 32'(bus.instr_fetch_stall), 32'd0);
        check("rst_addr",  32'(bus.instr_addr), 32'h100);
        check("rst_pc",    32'(bus.instr_pc), 32'h100);

        // Reset fetch
        bus.instr_ready = 1'b1;
        bus.instr_word  = 32'h00A00093;
        #1;
        check("rf_addr0", 32'(bus.instr_addr), 32'h100);
        tick();
        bus.instr_ready = 1'b0;
        #1;
        check("rf_addr1", 32'(bus.instr_addr), 32'h102);
        check("rf_valid", 32'(bus.instr_valid), 32'd1);
        check("rf_comp",  32'(bus.instr_compressed), 32'd0);
        check("rf_pc",    32'(bus.instr_pc), 32'h100);
        check("rf_data",  bus.instr_data, 32'h00A00093);
        take_one();
        check("rf_empty", 32'(bus.instr_valid), 32'd0);
        check("rf_pc2",   32'(bus.instr_pc), 32'h102);

        // Fill and stall
        push(32'hAAAA0013);
        push(32'hBBBB0023);
        push(32'hCCCC0033);
        check("fs_stall6", 32'(bus.instr_fetch_stall), 32'd0);
        push(32'hDDDD0043);
        check("fs_stall8", 32'(bus.instr_fetch_stall), 32'd1);
        check("fs_count8", 32'(dut.count), 32'd8);
        check("fs_addr",   32'(bus.instr_addr), 32'h10A);
        check("fs_data0",  bus.instr_data, 32'hAAAA0013);
        check("fs_pc0",    32'(bus.instr_pc), 32'h102);
        bus.cpu_take = 1'b1;
        #1;
        check("fs_stall_popcyc", 32'(bus.instr_fetch_stall), 32'd1);
        tick();
        bus.cpu_take = 1'b0;
        #1;
        check("fs_stall_rel", 32'(bus.instr_fetch_stall), 32'd0);
        check("fs_count6",    32'(dut.count), 32'd6);
        check("fs_pc1",       32'(bus.instr_pc), 32'h104);
        check("fs_data1",     bus.instr_data, 32'hBBBB0023);
        take_one();
        take_one();
        take_one();
        check("fs_drained", 32'(bus.instr_valid), 32'd0);
        check("fs_pc4",     32'(bus.instr_pc), 32'h10A);

        // Compressed mix
        push(32'h45010505);
        check("cm_valid0", 32'(bus.instr_valid), 32'd1);
        check("cm_comp0",  32'(bus.instr_compressed), 32'd1);
        check("cm_lo0",    32'(bus.instr_data[15:0]), 32'h0505);
        check("cm_pc0",    32'(bus.instr_pc), 32'h10A);
        take_one();
        check("cm_comp1",  32'(bus.instr_compressed), 32'd1);
        check("cm_lo1",    32'(bus.instr_data[15:0]), 32'h4501);
        check("cm_pc1",    32'(bus.instr_pc), 32'h10B);
        take_one();
        check("cm_empty",  32'(bus.instr_valid), 32'd0);
        check("cm_pc2",    32'(bus.instr_pc), 32'h10C);
        push(32'h00930001);
        check("cm_comp2",  32'(bus.instr_compressed), 32'd1);
        check("cm_lo2",    32'(bus.instr_data[15:0]), 32'h0001);
        take_one();
        check("cm_half32", 32'(bus.instr_valid), 32'd0);
        check("cm_pc3",    32'(bus.instr_pc), 32'h10D);
        push(32'hABCD0500);
        check("cm_valid3", 32'(bus.instr_valid), 32'd1);
        check("cm_comp3",  32'(bus.instr_compressed), 32'd0);
        check("cm_data3",  bus.instr_data, 32'h05000093);
        take_one();
        check("cm_pc4",    32'(bus.instr_pc), 32'h10F);

        // Jump discard
        bus.cpu_jump      = 1'b1;
        bus.cpu_jump_addr = 23'h000800;
        bus.instr_ready   = 1'b1;
        bus.instr_word    = 32'hDEADBEEF;
        #1;
        check("jd_jump_hi", 32'(bus.instr_jump), 32'd1);
        tick();
        bus.cpu_jump   = 1'b0;
        bus.instr_word = 32'hCAFEF00D;
        #1;
        check("jd_jump_lo", 32'(bus.instr_jump), 32'd0);
        check("jd_addr",    32'(bus.instr_addr), 32'h800);
        check("jd_valid0",  32'(bus.instr_valid), 32'd0);
        tick();
        bus.instr_ready = 1'b0;
        #1;
        check("jd_count",  32'(dut.count), 32'd0);
        check("jd_valid1", 32'(bus.instr_valid), 32'd0);
        check("jd_addr2",  32'(bus.instr_addr), 32'h800);
        push(32'h00004505);
        check("jd_valid2", 32'(bus.instr_valid), 32'd1);
        check("jd_pc",     32'(bus.instr_pc), 32'h800);
        check("jd_lo",     32'(bus.instr_data[15:0]), 32'h4505);
        check("jd_addr3",  32'(bus.instr_addr), 32'h802);

        // Simultaneous push/pop
        do_jump(23'h000900);
        push(32'h55550013);
        check("pp_count0", 32'(dut.count), 32'd2);
        check("pp_data0",  bus.instr_data, 32'h55550013);
        bus.instr_ready = 1'b1;
        bus.instr_word  = 32'h66660023;
        bus.cpu_take    = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        bus.cpu_take    = 1'b0;
        #1;
        check("pp_count1", 32'(dut.count), 32'd2);
        check("pp_data1",  bus.instr_data, 32'h66660023);
        check("pp_pc",     32'(bus.instr_pc), 32'h902);
        check("pp_valid",  32'(bus.instr_valid), 32'd1);

        // Address wrap
        do_jump(23'h7FFFFE);
        check("aw_addr0", 32'(bus.instr_addr), 32'h7FFFFE);
        push(32'h00010001);
        check("aw_addr1", 32'(bus.instr_addr), 32'h000000);
        check("aw_pc0",   32'(bus.instr_pc), 32'h7FFFFE);
        check("aw_valid", 32'(bus.instr_valid), 32'd1);
        take_one();
        check("aw_pc1",   32'(bus.instr_pc), 32'h7FFFFF);
        check("aw_lo1",   32'(bus.instr_data[15:0]), 32'h0001);
        take_one();
        check("aw_pc2",   32'(bus.instr_pc), 32'h000000);
        check("aw_empty", 32'(bus.instr_valid), 32'd0);

        // Reset mid-fetch, with a word returned in the reset cycle
        push(32'h12340013);
        rst             = 1'b1;
        bus.instr_ready = 1'b1;
        bus.instr_word  = 32'h77770013;
        tick();
        rst             = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        check("rm_addr",  32'(bus.instr_addr), 32'h100);
        check("rm_pc",    32'(bus.instr_pc), 32'h100);
        check("rm_count", 32'(dut.count), 32'd0);
        check("rm_valid", 32'(bus.instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tinyqv_instr_prefetch.md
# tinyqv_instr_prefetch

Instruction prefetch buffer between the TinyQV memory controller's instruction port and the CPU decoder. It generates the sequential fetch address, takes each 32-bit word returned by the controller into a halfword FIFO, and presents one aligned 16- or 32-bit instruction at a time to the decoder. It applies fetch back-pressure through `instr_fetch_stall` and handles jumps: on a jump it redirects the address, flushes the FIFO and discards any word still in flight.

## Interface
- `DEPTH_HW`, 8: FIFO depth in 16-bit halfwords; power of 2, at least 4.
- `RESET_ADDR`, 23'h000000: halfword address of the first fetch after reset.

- `clk` in 1: clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `cpu_jump` in 1: redirect request from the CPU.
- `cpu_jump_addr` in 23 [23:1]: jump target, as a halfword address.
- `cpu_take` in 1: decoder consumes the presented instruction this cycle.
- `instr_valid` out 1: `instr_data` holds a complete instruction.
- `instr_data` out 32: presented instruction; bits [15:0] are the halfword at `instr_pc`.
- `instr_compressed` out 1: high when `instr_data[1:0] != 2'b11` (16-bit instruction).
- `instr_pc` out 23 [23:1]: address of the presented instruction.
- `instr_addr` out 23 [23:1]: next fetch address, to the memory controller.
- `instr_jump` out 1: restart pulse, to the memory controller.
- `instr_fetch_stall` out 1: hold the final byte of the current fetch.
- `instr_ready` in 1: memory controller returns a fetched word this cycle.
- `instr_word` in 32: fetched word (`data_from_read`); bits [15:0] are at `instr_addr`.

## Operation
- **State**
  - Halfword array `buf[DEPTH_HW]`.
  - Read pointer `rd` and write pointer `wr`, each log2(DEPTH_HW) bits, wrapping modulo DEPTH_HW.
  - `count`, 0..DEPTH_HW.
  - `instr_pc` register and `instr_addr` register.
  - `discard` flag, 1 bit.
- **Reset**
  - `count=0`, `rd=wr=0`, `discard=0`.
  - `instr_pc=instr_addr=RESET_ADDR`.
  - Outputs after reset: `instr_valid=0`, `instr_jump=0`, `instr_fetch_stall=0`.
- **Push**, when `instr_ready && !cpu_jump && !discard`:
  - `buf[wr]<=instr_word[15:0]`, `buf[wr+1]<=instr_word[31:16]`.
  - `wr+=2`, `instr_addr+=2`.
  - Address arithmetic is modulo 2^23 and wraps silently.
- **Present**
  - `instr_data={buf[rd+1],buf[rd]}`.
  - `instr_valid=(count>=1 && instr_compressed) || count>=2`.
  - When `instr_compressed`, the upper 16 bits of `instr_data` are don't-care.
- **Pop**, when `cpu_take && instr_valid && !cpu_jump`:
  - n=1 if compressed, else n=2.
  - `rd+=n`, `instr_pc+=n`.
  - `cpu_take` while `instr_valid=0` is ignored.
- **Count**: `count <= count + (push?2:0) - (pop?n:0)`. Push and pop in the same cycle are both applied.
- **Back-pressure**: `instr_fetch_stall = (DEPTH_HW - count) < 2`. This is combinational from the registered `count` only; a pop in the same cycle does not release it.
- **Jump**
  - `instr_jump = cpu_jump`, combinational pass-through.
  - On a jump cycle: `count=0`, `rd=wr=0`, `instr_pc=instr_addr=cpu_jump_addr`, `discard<=1`.
  - A jump has priority over push and pop in the same cycle.
- **Discard window**
  - `discard` clears on the next non-jump cycle, so any `instr_ready` is dropped in the jump cycle and the following cycle.
  - This covers the word already in flight through the controller's registered restart.
  - Back-to-back jumps extend the window.
- **Overflow**: a push with `count > DEPTH_HW-2` is a protocol violation. A simulation assertion fires, and the push is dropped (`count` unchanged).

## Timing
- Fetch to present latency:
  - `instr_ready` in cycle T makes `instr_valid=1` in T+1, if the FIFO was empty.
  - `instr_pc` is unchanged by a push.
- Pop takes effect on the clock edge; the next instruction is presented in the following cycle.
  - Sustained 1 instruction/cycle is possible while `count>=2`.
- Jump timing:
  - `cpu_jump` in cycle T gives `instr_jump=1` in T.
  - The new `instr_addr` is visible in T+1, when the controller's `start_instr` samples it.
  - `instr_valid=0` from T+1 until the first post-jump word arrives.
- Stall timing:
  - Asserts in the cycle after the push that leaves fewer than 2 free halfwords.
  - Deasserts in the cycle after the pop that frees space.
- Reset mid-fetch:
  - All state returns to reset values on the next edge.
  - `instr_ready` in the reset cycle is ignored.

## Test plan
- **Reset fetch**
  - Stimulus: reset with `RESET_ADDR=23'h000100`; controller returns 32'h00A00093.
  - Required: `instr_addr` reads 23'h000100, then 23'h000102 after the word; `instr_valid=1`, `instr_compressed=0`, `instr_pc=23'h000100`, `instr_data=32'h00A00093` one cycle later.
- **Fill and stall**
  - Stimulus: DEPTH_HW=8, no `cpu_take`, four words returned.
  - Required: `instr_fetch_stall=1` once `count=8`; one take of a 32-bit instruction drops stall the next cycle; `count=6`.
- **Compressed mix**
  - Stimulus: words 32'h4501_0505 then 32'h0093_0001.
  - Required: presented in order 16'h0505 (compressed), 16'h4501 (compressed), 16'h0001 (compressed), then a 32-bit instruction spanning 16'h0093 and the next word; `instr_pc` advances 1,1,1,2.
- **Jump discard**
  - Stimulus: `cpu_jump` to 23'h000800 with `instr_ready` pulsed in the jump cycle and again the cycle after.
  - Required: both words dropped; `count=0`; `instr_jump` high in the jump cycle only; next accepted word is presented with `instr_pc=23'h000800`.
- **Simultaneous push/pop**
  - Stimulus: `count=2` (one 32-bit instruction), then `instr_ready` and `cpu_take` in the same cycle.
  - Required: `count=2` after the edge; the new word is presented.
- **Address wrap**
  - Stimulus: jump to 23'h7FFFFE, then one word returned.
  - Required: `instr_addr` becomes 23'h000000; popping two 16-bit instructions wraps `instr_pc` to 23'h000000.
